pipeline_stage_skid: RTL and testbench

Parametrised, flow-controlled pipeline stage register for the MIPS datapath, the successor to the fixed-width, always-enabled inter-stage registers. It provides the following:
- a valid/ready handshake with a two-entry skid buffer, so full throughput survives a registered ready;
- synchronous flush that inserts a bubble;
- automatic zeroing of control bits on bubbles;
- a saturating bubble counter.

One instance replaces a whole inter-stage register bank: control signals are packed into `ctrl`, datapath words into `data`.

---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/pipeline_stage_skid_if.sv | 31 +++
 rtl/pipe_entry_reg.sv | 33 +++
 rtl/pipeline_stage_skid.sv | 125 ++++++++++++
 tb/tb_pipeline_stage_skid.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for flow-controlled pipeline stage registers.
// The constants include the default EX/MEM packing widths and the occupancy encodings.
package pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    localparam logic [1:0] PIPE_OCC_EMPTY = 2'd0;
    localparam logic [1:0] PIPE_OCC_FULL  = 2'd1;
    localparam logic [1:0] PIPE_OCC_SKID  = 2'd2;

    localparam int unsigned EXMEM_CTRL_W = 5;
    localparam int unsigned EXMEM_DATA_W = 128;

    function automatic logic [1:0] pipe_occupancy(input pipe_state_t s);
        case (s)
            FULL:    return PIPE_OCC_FULL;
            SKID:    return PIPE_OCC_SKID;
            default: return PIPE_OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_stage_skid_if.sv
// Handshake and status bundle for pipeline_stage_skid.
// The master modport is the driving environment and the slave modport is the stage itself.
interface pipeline_stage_skid_if
    import pipeline_pkg::*;
#(
    parameter int unsigned CTRL_WIDTH  = EXMEM_CTRL_W,
    parameter int unsigned DATA_WIDTH  = EXMEM_DATA_W,
    parameter int unsigned COUNT_WIDTH = 16
);
    logic                   flush_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [CTRL_WIDTH-1:0]  ctrl_i;
    logic [DATA_WIDTH-1:0]  data_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [CTRL_WIDTH-1:0]  ctrl_o;
    logic [DATA_WIDTH-1:0]  data_o;
    logic [1:0]             occupancy_o;
    logic [COUNT_WIDTH-1:0] bubble_count_o;

    modport master (
        output flush_i, in_valid_i, ctrl_i, data_i, out_ready_i,
        input  in_ready_o, out_valid_o, ctrl_o, data_o, occupancy_o, bubble_count_o
    );

    modport slave (
        input  flush_i, in_valid_i, ctrl_i, data_i, out_ready_i,
        output in_ready_o, out_valid_o, ctrl_o, data_o, occupancy_o, bubble_count_o
    );
endinterface

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: a valid flag plus ctrl/data payload with load, clear-valid and sync reset.
// The payload is kept when the entry is cleared; only reset zeroes it.
module pipe_entry_reg #(
    parameter int unsigned CTRL_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [CTRL_WIDTH-1:0] ctrl_d,
    input  logic [DATA_WIDTH-1:0] data_d,
    output logic                  valid_q,
    output logic [CTRL_WIDTH-1:0] ctrl_q,
    output logic [DATA_WIDTH-1:0] data_q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            if (load) begin
                ctrl_q <= ctrl_d;
                data_q <= data_d;
            end
            if (clear)
                valid_q <= 1'b0;
            else if (load)
                valid_q <= 1'b1;
        end
    end
endmodule

// File: rtl/pipeline_stage_skid.sv
// Flow-controlled inter-stage register with a two-entry skid buffer, flush and a saturating bubble counter.
// Ready is registered (the inverse of skid occupancy), so there is no combinational path from out_ready_i to in_ready_o.
module pipeline_stage_skid
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = EXMEM_DATA_W,
    parameter int unsigned CTRL_WIDTH  = EXMEM_CTRL_W,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input logic                  clk,
    input logic                  reset,
    pipeline_stage_skid_if.slave bus
);
    pipe_state_t            state_q, state_d;
    logic                   main_load, main_clear, main_from_skid;
    logic                   skid_load, skid_clear;
    logic                   main_valid, skid_valid;
    logic [CTRL_WIDTH-1:0]  main_ctrl, skid_ctrl, main_ctrl_d;
    logic [DATA_WIDTH-1:0]  main_data, skid_data, main_data_d;
    logic                   in_ready, in_xfer, out_xfer;
    logic [COUNT_WIDTH-1:0] bubble_q;

    assign in_ready    = ~skid_valid;
    assign in_xfer     = bus.in_valid_i & in_ready;
    assign out_xfer    = main_valid & bus.out_ready_i;
    assign main_ctrl_d = main_from_skid ? skid_ctrl : bus.ctrl_i;
    assign main_data_d = main_from_skid ? skid_data : bus.data_i;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // Flush clears both valids but suppresses every load, so held payloads survive.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (bus.flush_i) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = FULL;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                        state_d   = SKID;
                    end else if (out_xfer) begin
                        main_clear = 1'b1;
                        state_d    = EMPTY;
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        bus.in_ready_o     = in_ready;
        bus.out_valid_o    = main_valid;
        bus.ctrl_o         = main_valid ? main_ctrl : '0;
        bus.data_o         = main_data;
        bus.occupancy_o    = pipe_occupancy(state_q);
        bus.bubble_count_o = bubble_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            bubble_q <= '0;
        else if (bus.out_ready_i && !main_valid && (bubble_q != '1))
            bubble_q <= bubble_q + 1'b1;
    end

    pipe_entry_reg #(
        .CTRL_WIDTH(CTRL_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (main_load),
        .clear  (main_clear),
        .ctrl_d (main_ctrl_d),
        .data_d (main_data_d),
        .valid_q(main_valid),
        .ctrl_q (main_ctrl),
        .data_q (main_data)
    );

    pipe_entry_reg #(
        .CTRL_WIDTH(CTRL_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .clear  (skid_clear),
        .ctrl_d (bus.ctrl_i),
        .data_d (bus.data_i),
        .valid_q(skid_valid),
        .ctrl_q (skid_ctrl),
        .data_q (skid_data)
    );
endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Directed bench for pipeline_stage_skid; a second instance with a 4-bit counter exercises saturation.
module tb_pipeline_stage_skid;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipeline_stage_skid_if #(.CTRL_WIDTH(5), .DATA_WIDTH(128), .COUNT_WIDTH(16)) bus ();
    pipeline_stage_skid_if #(.CTRL_WIDTH(5), .DATA_WIDTH(128), .COUNT_WIDTH(4))  sat_bus ();

    pipeline_stage_skid #(.DATA_WIDTH(128), .CTRL_WIDTH(5), .COUNT_WIDTH(16)) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    pipeline_stage_skid #(.DATA_WIDTH(128), .CTRL_WIDTH(5), .COUNT_WIDTH(4)) u_sat (
        .clk  (clk),
        .reset(reset),
        .bus  (sat_bus)
    );

    task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_i        = 1'b0;
        bus.in_valid_i     = 1'b0;
        bus.ctrl_i         = '0;
        bus.data_i         = '0;
        bus.out_ready_i    = 1'b0;
        sat_bus.flush_i    = 1'b0;
        sat_bus.in_valid_i = 1'b0;
        sat_bus.ctrl_i     = '0;
        sat_bus.data_i     = '0;
        sat_bus.out_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load_skid_4_5();
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.ctrl_i      = 5'h1F;
        bus.data_i      = 128'd4;
        step();
        bus.data_i      = 128'd5;
        step();
        bus.in_valid_i  = 1'b0;
        check("skid_occ", bus.occupancy_o, 2);
        check("skid_in_ready", bus.in_ready_o, 0);
        check("skid_data_main", bus.data_o, 4);
        check("skid_ctrl_main", bus.ctrl_o, 5'h1F);
    endtask

    initial begin
        int unsigned next_in;
        int unsigned exp_out;
        int unsigned max_occ;
        int unsigned stall_cycles;
        logic        took;

        // Inputs offered during reset must be ignored.
        idle_inputs();
        bus.in_valid_i = 1'b1;
        bus.data_i     = 128'hDEAD;
        bus.ctrl_i     = 5'h1F;
        step();
        step();
        reset = 1'b0;
        idle_inputs();
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_ctrl", bus.ctrl_o, 0);
        check("rst_data", bus.data_o, 0);
        check("rst_occ", bus.occupancy_o, 0);
        check("rst_bubble", bus.bubble_count_o, 0);
        check("rst_in_ready", bus.in_ready_o, 1);

        // First entry lands one cycle after acceptance.
        bus.in_valid_i  = 1'b1;
        bus.data_i      = 128'd1;
        bus.ctrl_i      = 5'b10101;
        bus.out_ready_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        check("first_valid", bus.out_valid_o, 1);
        check("first_data", bus.data_o, 1);
        check("first_ctrl", bus.ctrl_o, 5'b10101);
        check("first_occ", bus.occupancy_o, 1);
        step();
        check("first_drain_valid", bus.out_valid_o, 0);
        check("first_drain_ctrl", bus.ctrl_o, 0);
        check("first_drain_data_held", bus.data_o, 1);

        // Full-throughput streaming of 1..8.
        do_reset();
        bus.out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid_i = 1'b1;
            bus.data_i     = 128'(i);
            bus.ctrl_i     = 5'(i);
            step();
            check("stream_data", bus.data_o, 128'(i));
            check("stream_valid", bus.out_valid_o, 1);
            check("stream_in_ready", bus.in_ready_o, 1);
        end
        bus.in_valid_i = 1'b0;
        step();
        check("stream_end_occ", bus.occupancy_o, 0);

        // One-cycle downstream stall after entry 3 is presented.
        do_reset();
        next_in = 1; exp_out = 1; max_occ = 0; stall_cycles = 0;
        for (int c = 0; c < 14; c++) begin
            bus.out_ready_i = (c != 4);
            bus.in_valid_i  = (next_in <= 8);
            bus.data_i      = 128'(next_in);
            bus.ctrl_i      = 5'h03;
            if (bus.occupancy_o > max_occ) max_occ = bus.occupancy_o;
            if (!bus.in_ready_o) stall_cycles++;
            if (bus.out_valid_o && bus.out_ready_i) begin
                check("stall_order", bus.data_o, 128'(exp_out));
                exp_out++;
            end
            took = bus.in_valid_i && bus.in_ready_o;
            step();
            if (took) next_in++;
        end
        bus.in_valid_i = 1'b0;
        check("stall_delivered", exp_out, 9);
        check("stall_max_occ", max_occ, 2);
        check("stall_ready_low_cycles", stall_cycles, 1);
        check("stall_final_occ", bus.occupancy_o, 0);

        // Flush from SKID discards 4, 5 and the concurrently offered 6.
        do_reset();
        load_skid_4_5();
        bus.flush_i    = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.data_i     = 128'd6;
        step();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        check("flush_valid", bus.out_valid_o, 0);
        check("flush_ctrl", bus.ctrl_o, 0);
        check("flush_occ", bus.occupancy_o, 0);
        check("flush_in_ready", bus.in_ready_o, 1);
        check("flush_data_kept", bus.data_o, 4);
        bus.out_ready_i = 1'b1;
        step();
        check("flush_no_6_valid", bus.out_valid_o, 0);
        check("flush_no_6_data", bus.data_o, 4);

        // Flush together with an input in EMPTY stores nothing.
        bus.out_ready_i = 1'b0;
        bus.flush_i     = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.data_i      = 128'd9;
        step();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        check("flush_empty_occ", bus.occupancy_o, 0);
        check("flush_empty_valid", bus.out_valid_o, 0);

        // Bubble counter, including 4-bit saturation and immunity to flush.
        do_reset();
        bus.out_ready_i     = 1'b1;
        sat_bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("bubble_3", bus.bubble_count_o, 3);
        check("bubble_sat_3", sat_bus.bubble_count_o, 3);
        for (int i = 0; i < 17; i++) step();
        check("bubble_20", bus.bubble_count_o, 20);
        check("bubble_sat_15", sat_bus.bubble_count_o, 15);
        bus.flush_i     = 1'b1;
        sat_bus.flush_i = 1'b1;
        step();
        bus.flush_i     = 1'b0;
        sat_bus.flush_i = 1'b0;
        check("bubble_flush_21", bus.bubble_count_o, 21);
        check("bubble_sat_hold", sat_bus.bubble_count_o, 15);
        sat_bus.out_ready_i = 1'b0;

        // Reset while in SKID.
        load_skid_4_5();
        check("pre_rst_bubble", bus.bubble_count_o, 21);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_valid", bus.out_valid_o, 0);
        check("midrst_ctrl", bus.ctrl_o, 0);
        check("midrst_data", bus.data_o, 0);
        check("midrst_occ", bus.occupancy_o, 0);
        check("midrst_bubble", bus.bubble_count_o, 0);
        check("midrst_in_ready", bus.in_ready_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
